counter_8b: RTL and testbench

- 8-bit synchronous up-counter with count enable, synchronous initialise, and carry-out.
- Used as an address sequencer. The memory-scan harness forms a 13-bit address as {Res, 5'h00}, so each count steps through one 32-byte opcode slot per clock.
- Res therefore walks every slot base 0x000, 0x020, … 0x1FE0 in turn.

---
 rtl/counter_8b.sv | 30 +++
 tb/tb_counter_8b.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_8b.sv
// Address sequencer: WIDTH-bit up-counter with enable, sync init and carry-out; Res updates one Clk after C/Init.
// No backpressure: counts on every enabled edge, wraps modulo 2^WIDTH; Co is combinational for cascading.
module counter_8b #(
    parameter int                 WIDTH      = 8,
    parameter logic [WIDTH-1:0]   INIT_VALUE = '0
) (
    input  logic             C,
    input  logic             Init,
    input  logic             Clk,
    input  logic             Rst,
    output logic [WIDTH-1:0] Res,
    output logic             Co
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Init outranks C so a cascade can be reloaded in lockstep mid-count.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Res <= INIT_VALUE;
        end else if (Init) begin
            Res <= INIT_VALUE;
        end else if (C) begin
            Res <= Res + ONE;
        end
    end

    assign Co = C & ~Init & ~Rst & (&Res);

endmodule

// File: tb/tb_counter_8b.sv
// Scoreboard bench for counter_8b: expected Res pushed per driven edge, popped after the edge.
module tb_counter_8b;

    logic       Clk;
    logic       Rst;
    logic       C;
    logic       Init;
    logic [7:0] Res;
    logic       Co;

    logic       cas_c;
    logic       cas_init;
    logic [7:0] lo_res;
    logic [7:0] hi_res;
    logic       lo_co;
    logic       hi_co;

    int n_checks;
    int n_fail;

    logic [7:0] model;
    logic [7:0] exp_q[$];
    logic       co_pre;

    counter_8b dut (
        .C    (C),
        .Init (Init),
        .Clk  (Clk),
        .Rst  (Rst),
        .Res  (Res),
        .Co   (Co)
    );

    counter_8b u_lo (
        .C    (cas_c),
        .Init (cas_init),
        .Clk  (Clk),
        .Rst  (Rst),
        .Res  (lo_res),
        .Co   (lo_co)
    );

    counter_8b u_hi (
        .C    (lo_co),
        .Init (cas_init),
        .Clk  (Clk),
        .Rst  (Rst),
        .Res  (hi_res),
        .Co   (hi_co)
    );

    initial begin
        Clk = 1'b0;
        forever #50 Clk = ~Clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required completion");
        $fatal(1, "watchdog");
    end

    // Drives one edge's inputs at negedge, records Co just before the edge, pushes the model's next Res.
    task automatic drive_edge(input logic c, input logic init);
        @(negedge Clk);
        C    = c;
        Init = init;
        #10;
        co_pre = Co;
        if (init)
            model = 8'h00;
        else if (c)
            model = model + 8'h01;
        exp_q.push_back(model);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0] e;
        Rst = 1'b0; C = 1'b0; Init = 1'b0; cas_c = 1'b0; cas_init = 1'b0;
        #5 Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (Res !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_res: got %h required 00", Res);
        end
        n_checks++;
        if (Co !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_co: got %b required 0", Co);
        end
        @(negedge Clk);
        Rst = 1'b0;
        model = 8'h00;
        drive_edge(1'b0, 1'b1);
        repeat (8'h5A) drive_edge(1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (Res !== e && exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL reset_precount: got %h required %h", Res, e);
            end
        end
        // Pulse Rst between edges with C still high.
        @(negedge Clk);
        #20 Rst = 1'b1;
        #5;
        n_checks++;
        if (Res !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: got %h required 00", Res);
        end
        n_checks++;
        if (Co !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_co: got %b required 0", Co);
        end
        @(posedge Clk);
        #1;
        n_checks++;
        if (Res !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: got %h required 00", Res);
        end
        @(negedge Clk);
        Rst = 1'b0;
        C   = 1'b0;
        model = 8'h00;
    endtask

    task automatic test_init_count;
        logic [7:0]  e;
        logic [12:0] addr;
        drive_edge(1'b1, 1'b0);
        drive_edge(1'b0, 1'b1);
        e = exp_q.pop_front();
        e = exp_q.pop_front();
        n_checks++;
        if (Res !== e) begin
            n_fail++;
            $display("FAIL init_load: got %h required %h", Res, e);
        end
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b1, 1'b0);
            e = exp_q.pop_front();
            addr = {e, 5'h00};
            n_checks++;
            if (Res !== e) begin
                n_fail++;
                $display("FAIL init_count[%0d]: got %h required %h", i, Res, e);
            end
            n_checks++;
            if ({Res, 5'h00} !== addr) begin
                n_fail++;
                $display("FAIL init_addr[%0d]: got %h required %h", i, {Res, 5'h00}, addr);
            end
        end
    endtask

    task automatic test_hold;
        logic [7:0] e;
        drive_edge(1'b0, 1'b1);
        repeat (8'h37) drive_edge(1'b1, 1'b0);
        while (exp_q.size() > 1) e = exp_q.pop_front();
        e = exp_q.pop_front();
        n_checks++;
        if (Res !== e) begin
            n_fail++;
            $display("FAIL hold_setup: got %h required %h", Res, e);
        end
        for (int i = 0; i < 5; i++) begin
            drive_edge(1'b0, 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if (Res !== e || Res !== 8'h37) begin
                n_fail++;
                $display("FAIL hold_res[%0d]: got %h required 37", i, Res);
            end
            n_checks++;
            if (co_pre !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_co[%0d]: got %b required 0", i, co_pre);
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] e;
        logic       exp_co;
        int         pulses;
        int         last_pulse;
        drive_edge(1'b0, 1'b1);
        repeat (255) drive_edge(1'b1, 1'b0);
        while (exp_q.size() > 0) e = exp_q.pop_front();
        n_checks++;
        if (Res !== 8'hFF) begin
            n_fail++;
            $display("FAIL wrap_top: got %h required ff", Res);
        end
        drive_edge(1'b1, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (co_pre !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_co_high: got %b required 1", co_pre);
        end
        n_checks++;
        if (Res !== e) begin
            n_fail++;
            $display("FAIL wrap_res: got %h required %h", Res, e);
        end
        drive_edge(1'b1, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (co_pre !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_co_low: got %b required 0", co_pre);
        end
        // Long run from zero: Co at cycles 255, 511, 767.
        drive_edge(1'b0, 1'b1);
        e = exp_q.pop_front();
        pulses = 0;
        last_pulse = -1;
        for (int i = 0; i < 900; i++) begin
            exp_co = (model == 8'hFF);
            drive_edge(1'b1, 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if (co_pre !== exp_co || Res !== e) begin
                n_fail++;
                $display("FAIL wrap_run[%0d]: got co=%b res=%h required co=%b res=%h",
                         i, co_pre, Res, exp_co, e);
            end
            if (co_pre === 1'b1) begin
                if (last_pulse >= 0) begin
                    n_checks++;
                    if (i - last_pulse != 256) begin
                        n_fail++;
                        $display("FAIL wrap_spacing: got %0d required 256", i - last_pulse);
                    end
                end
                last_pulse = i;
                pulses++;
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL wrap_pulses: got %0d required 3", pulses);
        end
    endtask

    task automatic test_priority;
        logic [7:0] e;
        drive_edge(1'b0, 1'b1);
        repeat (255) drive_edge(1'b1, 1'b0);
        while (exp_q.size() > 0) e = exp_q.pop_front();
        n_checks++;
        if (Res !== 8'hFF) begin
            n_fail++;
            $display("FAIL prio_setup: got %h required ff", Res);
        end
        drive_edge(1'b1, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if (co_pre !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_co: got %b required 0", co_pre);
        end
        n_checks++;
        if (Res !== e || Res !== 8'h00) begin
            n_fail++;
            $display("FAIL prio_res: got %h required 00", Res);
        end
        drive_edge(1'b0, 1'b0);
        e = exp_q.pop_front();
    endtask

    task automatic test_cascade;
        @(negedge Clk);
        cas_init = 1'b1;
        cas_c    = 1'b0;
        @(negedge Clk);
        cas_init = 1'b0;
        cas_c    = 1'b1;
        repeat (255) @(negedge Clk);
        #10;
        n_checks++;
        if (lo_res !== 8'hFF || hi_res !== 8'h00 || lo_co !== 1'b1) begin
            n_fail++;
            $display("FAIL cascade_pre: got hi=%h lo=%h co=%b required hi=00 lo=ff co=1",
                     hi_res, lo_res, lo_co);
        end
        @(posedge Clk);
        #1;
        cas_c = 1'b0;
        n_checks++;
        if (hi_res !== 8'h01 || lo_res !== 8'h00) begin
            n_fail++;
            $display("FAIL cascade_final: got hi=%h lo=%h required hi=01 lo=00", hi_res, lo_res);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model    = 8'h00;
        co_pre   = 1'b0;
        test_reset();
        test_init_count();
        test_hold();
        test_wrap();
        test_priority();
        test_cascade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
